// File: rtl/hex_keypad_encoder.sv
// hex_keypad_encoder: scans a 4x4 active-low hex keypad one column at a time.
// Each press is debounced, encoded to a hex digit, and shifted into a 32-bit
// entry register. Row lines are asynchronous and pass through a 2-flop
// synchronizer before any decision is made.
//
// Handshake: o_key_valid is a one-cycle strobe with no back-pressure. o_key is
// valid on the strobe cycle and holds its value until the next accepted key.
// o_value and o_digit_count already include the new digit on that same cycle.
module hex_keypad_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_row,
    input  logic        i_clear,
    output logic [3:0]  o_col,
    output logic [3:0]  o_key,
    output logic        o_key_valid,
    output logic [31:0] o_value,
    output logic [3:0]  o_digit_count
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);
    localparam logic [3:0]       MAX_DIGITS = 4'd8;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    // Row synchronizer.
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;

    // Dwell timer and scan state.
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    state_t           state_q;
    logic [3:0]       col_q;
    logic [1:0]       col_idx_q;
    logic [1:0]       key_row_q;
    logic [DB_W-1:0]  stable_q;
    logic [DB_W-1:0]  stable_d;
    logic [DB_W-1:0]  release_q;
    logic [DB_W-1:0]  release_d;

    // Registered outputs.
    logic [3:0]       key_q;
    logic             key_valid_q;
    logic [31:0]      value_q;
    logic [3:0]       count_q;
    logic [3:0]       count_d;

    // Sample classification and decoded key.
    logic             sample;
    logic             row_none;
    logic             row_single;
    logic [1:0]       row_idx;
    logic             accept;
    logic [3:0]       code_d;

    // Keypad legend: row r, column c.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'hE;
            4'b11_01: k = 4'h0;
            4'b11_10: k = 4'hF;
            4'b11_11: k = 4'hD;
            default:  k = 4'h0;
        endcase
        return k;
    endfunction

    // Bring the asynchronous row lines into the clock domain (idle high).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= i_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Classify the synchronized rows and derive sample/accept conditions.
    always_comb begin
        row_none   = 1'b0;
        row_single = 1'b0;
        row_idx    = 2'd0;
        case (row_sync_q)
            4'b1111: row_none = 1'b1;
            4'b1110: begin row_single = 1'b1; row_idx = 2'd0; end
            4'b1101: begin row_single = 1'b1; row_idx = 2'd1; end
            4'b1011: begin row_single = 1'b1; row_idx = 2'd2; end
            4'b0111: begin row_single = 1'b1; row_idx = 2'd3; end
            default: ;
        endcase

        sample    = (div_q == DIV_LAST);
        div_d     = sample ? '0 : div_q + DIV_W'(1);
        stable_d  = stable_q + DB_W'(1);
        release_d = release_q + DB_W'(1);

        // A single-key accept happens straight from SCAN only when one
        // clean sample is enough. Otherwise it is the last DEBOUNCE sample.
        accept = 1'b0;
        if (sample && row_single) begin
            if (state_q == ST_SCAN && DEBOUNCE_SCANS == 1) begin
                accept = 1'b1;
            end else if (state_q == ST_DEBOUNCE && row_idx == key_row_q
                         && stable_d == DB_TARGET) begin
                accept = 1'b1;
            end
        end

        // The column is held from the first sample onwards, so the current
        // row and column identify the key being accepted.
        code_d  = key_code(row_idx, col_idx_q);
        count_d = (count_q >= MAX_DIGITS) ? MAX_DIGITS : count_q + 4'd1;
    end

    // Dwell counter: one sample per SCAN_DIV cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Scan / debounce / release FSM, including column drive.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_SCAN;
            col_q     <= 4'b1110;
            col_idx_q <= 2'd0;
            key_row_q <= 2'd0;
            stable_q  <= '0;
            release_q <= '0;
        end else if (accept) begin
            state_q   <= ST_RELEASE;
            release_q <= '0;
            stable_q  <= '0;
        end else if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_single) begin
                        key_row_q <= row_idx;
                        stable_q  <= DB_W'(1);
                        state_q   <= ST_DEBOUNCE;
                    end else begin
                        col_q     <= {col_q[2:0], col_q[3]};
                        col_idx_q <= col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_single && row_idx == key_row_q) begin
                        stable_q <= stable_d;
                    end else begin
                        stable_q  <= '0;
                        state_q   <= ST_SCAN;
                        col_q     <= {col_q[2:0], col_q[3]};
                        col_idx_q <= col_idx_q + 2'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!row_none) begin
                        release_q <= '0;
                    end else if (release_d == DB_TARGET) begin
                        release_q <= '0;
                        state_q   <= ST_SCAN;
                        col_q     <= {col_q[2:0], col_q[3]};
                        col_idx_q <= col_idx_q + 2'd1;
                    end else begin
                        release_q <= release_d;
                    end
                end
                default: begin
                    state_q <= ST_SCAN;
                end
            endcase
        end
    end

    // Key strobe, entry shift register and digit count; clear beats accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            value_q     <= 32'h0;
            count_q     <= 4'd0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_q   <= code_d;
                value_q <= {value_q[27:0], code_d};
                count_q <= count_d;
            end
            if (i_clear) begin
                value_q <= 32'h0;
                count_q <= 4'd0;
            end
        end
    end

    assign o_col         = col_q;
    assign o_key         = key_q;
    assign o_key_valid   = key_valid_q;
    assign o_value       = value_q;
    assign o_digit_count = count_q;

    // The strobe is a single-cycle pulse.
    ap_strobe_single: assert property (@(posedge i_clk) disable iff (i_rst)
        key_valid_q |=> !key_valid_q);

    // Exactly one column is driven low.
    ap_col_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot(~col_q));

endmodule

// File: tb/tb_hex_keypad_encoder.sv
// Bench for hex_keypad_encoder: a keypad model drives the rows from the
// columns, and a scoreboard tracks the keys and entry value expected.
module tb_hex_keypad_encoder;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_drv;
    logic        clear;
    logic [3:0]  o_col;
    logic [3:0]  o_key;
    logic        o_key_valid;
    logic [31:0] o_value;
    logic [3:0]  o_digit_count;

    hex_keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .i_clk(clk), .i_rst(rst), .i_row(row_drv), .i_clear(clear),
        .o_col(o_col), .o_key(o_key), .o_key_valid(o_key_valid),
        .o_value(o_value), .o_digit_count(o_digit_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- keypad model ----------------
    logic [15:0] pressed;  // bit r*4+c = key at row r, column c held down
    logic [3:0]  key_map [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                    4'h4, 4'h5, 4'h6, 4'hB,
                                    4'h7, 4'h8, 4'h9, 4'hC,
                                    4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0]  col_seq [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !o_col[c]) row_drv[r] = 1'b0;
    end

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          n_pushed = 0;
    int          n_seen = 0;
    logic [31:0] mv = 32'h0;
    int          mc = 0;
    logic        clear_hold = 1'b0;
    logic        prev_valid = 1'b0;
    logic [39:0] exp_q[$];  // {key, value after accept, count after accept}

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_key(input logic [3:0] code);
        if (clear_hold) begin
            mv = 32'h0;
            mc = 0;
        end else begin
            mv = (mv << 4) | {28'h0, code};
            mc = (mc + 1 > 8) ? 8 : mc + 1;
        end
        exp_q.push_back({code, mv, 4'(mc)});
        n_pushed++;
    endtask

    always @(negedge clk) begin
        logic [39:0] e;
        if (o_key_valid) begin
            n_seen++;
            chk("strobe_gap", {39'h0, prev_valid}, 40'h0);
            chk("strobe_count", n_seen, n_pushed);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("key", {36'h0, o_key}, {36'h0, e[39:36]});
                chk("value_at_strobe", {8'h0, o_value}, {8'h0, e[35:4]});
                chk("count_at_strobe", {36'h0, o_digit_count}, {36'h0, e[3:0]});
            end
        end
        prev_valid = o_key_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic settle_check();
        chk("missing_strobe", exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            n_seen = n_pushed;
        end
        chk("idle_value", {8'h0, o_value}, {8'h0, mv});
        chk("idle_count", {36'h0, o_digit_count}, 40'(mc));
    endtask

    function automatic int key_pos(input logic [3:0] code);
        for (int i = 0; i < 16; i++)
            if (key_map[i] == code) return i;
        return 0;
    endfunction

    task automatic press_key(input logic [3:0] code, input int hold);
        pressed = 16'h1 << key_pos(code);
        expect_key(code);
        repeat (hold) @(negedge clk);
        pressed = 16'h0;
        repeat (60) @(negedge clk);
        settle_check();
    endtask

    task automatic wait_col(input logic [3:0] c);
        int n;
        n = 0;
        while (o_col != c && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("wait_col", {36'h0, o_col}, {36'h0, c});
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mv = 32'h0;
        mc = 0;
        repeat (3) @(negedge clk);
        settle_check();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int cnt;
        logic [3:0] prev_col;
        rst = 1'b1;
        clear = 1'b0;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_col", {36'h0, o_col}, 40'h0E);
        chk("rst_value", {8'h0, o_value}, 40'h0);
        chk("rst_count", {36'h0, o_digit_count}, 40'h0);
        chk("rst_valid", {39'h0, o_key_valid}, 40'h0);
        rst = 1'b0;

        // Column stepping with no key down.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("col_step", {36'h0, o_col}, {36'h0, col_seq[(k / SD) % 4]});
        end

        // Single key 5, held 40 cycles.
        press_key(4'h5, 40);

        // Keys 1..9 in sequence; oldest digit drops off the top.
        for (int d = 1; d <= 9; d++) press_key(4'(d), 60);
        chk("seq_value", {8'h0, o_value}, 40'h23456789);
        chk("seq_count", {36'h0, o_digit_count}, 40'h8);

        // 'D' held for only two samples: no strobe, column 3 released to 0.
        wait_col(4'b1110);
        wait_col(4'b0111);
        pressed = 16'h1 << 15;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2 * SD) pressed = 16'h0;
            if (o_col != 4'b0111) break;
        end
        pressed = 16'h0;
        chk("glitch_hold_cycles", n, 3 * SD);
        chk("glitch_next_col", {36'h0, o_col}, 40'h0E);
        repeat (30) @(negedge clk);
        settle_check();

        // Rows 0 and 2 on column 0 together: scanning never stalls.
        pressed = (16'h1 << 0) | (16'h1 << 8);
        repeat (8) @(negedge clk);
        cnt = 0;
        prev_col = o_col;
        for (int k = 0; k < 12 * SD; k++) begin
            @(negedge clk);
            if (o_col != prev_col) cnt++;
            prev_col = o_col;
        end
        chk("multi_col_steps", cnt, 12);
        pressed = 16'h0;
        repeat (30) @(negedge clk);
        settle_check();
        press_key(4'hA, 60);

        // Clear held across an accept: strobe fires, entry stays empty.
        pulse_clear();
        press_key(4'h1, 60);
        press_key(4'h2, 60);
        chk("pre_clear_value", {8'h0, o_value}, 40'h12);
        clear_hold = 1'b1;
        clear = 1'b1;
        press_key(4'h7, 60);
        clear = 1'b0;
        clear_hold = 1'b0;

        // Reset in the middle of debouncing key 4.
        wait_col(4'b0111);
        pressed = 16'h1 << 4;
        wait_col(4'b1110);
        repeat (2 * SD) @(negedge clk);
        chk("debounce_held_col", {36'h0, o_col}, 40'h0E);
        rst = 1'b1;
        #1;
        mv = 32'h0;
        mc = 0;
        chk("midrst_col", {36'h0, o_col}, 40'h0E);
        chk("midrst_key", {36'h0, o_key}, 40'h0);
        chk("midrst_valid", {39'h0, o_key_valid}, 40'h0);
        chk("midrst_value", {8'h0, o_value}, 40'h0);
        chk("midrst_count", {36'h0, o_digit_count}, 40'h0);
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        settle_check();

        // Randomized presses, glitches, multi-key chords and clears.
        for (int op = 0; op < 24; op++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: press_key(4'($urandom_range(0, 15)), $urandom_range(50, 70));
                3: begin
                    pressed = 16'h1 << $urandom_range(0, 15);
                    repeat ($urandom_range(1, 7)) @(negedge clk);
                    pressed = 16'h0;
                    repeat (30) @(negedge clk);
                    settle_check();
                end
                4: begin
                    n = $urandom_range(0, 3);
                    cnt = $urandom_range(1, 3);
                    pressed = (16'h1 << n) | (16'h1 << (((cnt + n / 4) % 4) * 4 + n));
                    repeat ($urandom_range(20, 40)) @(negedge clk);
                    pressed = 16'h0;
                    repeat (30) @(negedge clk);
                    settle_check();
                end
                default: pulse_clear();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hex_keypad_encoder.md
Name: hex_keypad_encoder

Overview:
- Scans a 4x4 matrix hex keypad and debounces it.
- Encodes each accepted keypress to a 4-bit hex digit and shifts the digit into a 32-bit entry register.
- This is the input-side counterpart of the seven-segment hex display path. It lets the user key a 32-bit word (register value, address, operand) into the RISC-V CPU board logic, and the same word can be shown on the 8-digit display.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before rows are sampled; must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical samples needed to accept a press or a release; must be >= 1.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_row  input  4  keypad row lines, active-low, asynchronous to i_clk.
- i_clear  input  1  synchronous pulse; clears o_value and o_digit_count.
- o_col  output  4  keypad column drive, active-low, exactly one bit low at all times.
- o_key  output  4  hex code of the most recently accepted key.
- o_key_valid  output  1  one-cycle strobe when a key is accepted.
- o_value  output  32  entry register; newest digit is in bits [3:0].
- o_digit_count  output  4  digits entered since reset or clear, saturating at 8.

Behaviour:
- Interface: one clock (i_clk); reset i_rst is asynchronous and active-high.
- Reset values:
  - o_col = 4'b1110 (column 0 driven).
  - o_key = 0, o_key_valid = 0, o_value = 0, o_digit_count = 0.
  - FSM = SCAN; all counters = 0; row synchronizer flops = 4'hF.
- i_row passes through a 2-flop synchronizer. All row decisions use the synchronized value.
- Dwell counter: counts 0..SCAN_DIV-1 and wraps. A "sample" happens on the cycle the counter equals SCAN_DIV-1.
- Sample classification: "single" = exactly one synced row bit low; "none" = all rows high; "multi" = two or more rows low.
- Key map (row r, column c), giving 16 codes:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D
- FSM states:
  - SCAN:
    - On sample: single -> latch row/column, stable count = 1, go to DEBOUNCE. If DEBOUNCE_SCANS = 1, accept immediately instead.
    - On sample: none or multi -> advance column (3 wraps to 0); o_col updates on the next cycle.
  - DEBOUNCE:
    - Column is held.
    - On sample: same single row -> stable count + 1.
    - On sample: any other result -> go to SCAN and advance column. No strobe.
    - When stable count reaches DEBOUNCE_SCANS: accept.
  - Accept (registered, one cycle):
    - o_key_valid = 1 and o_key = code.
    - o_value <= {o_value[27:0], code}.
    - o_digit_count = min(count + 1, 8).
    - Go to RELEASE with release count = 0.
  - RELEASE:
    - Column is held.
    - On sample: none -> release count + 1; single or multi -> release count = 0.
    - At DEBOUNCE_SCANS -> go to SCAN and advance column.
    - A key held indefinitely produces exactly one strobe.
- i_clear:
  - Sets o_value = 0 and o_digit_count = 0 on the next edge. Does not affect FSM, o_col or o_key.
  - If i_clear coincides with accept, clear wins: o_value = 0 and count = 0. The strobe still fires and o_key still updates.
- Shifting past 8 digits discards the oldest nibble (bits [31:28]). Count holds at 8.
- o_key_valid is never high on two consecutive cycles.
- Asserting i_rst in any state immediately returns all outputs and state to reset values, with no residual strobe.
- Latency from a stable press to the strobe: at most (2 + DEBOUNCE_SCANS + 4) × SCAN_DIV cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
1. Assert i_rst, release, row = 4'hF.
   -> o_col = 1110, o_value = 0, o_digit_count = 0. o_col steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, every 4 cycles.
2. Hold row1 low only while col1 is driven, for 40 cycles, then release.
   -> Exactly one o_key_valid with o_key = 5, o_value = 32'h5, count = 1. No further strobe. Scanning resumes after 3 clean samples.
3. Press the keys 1..9 in sequence, with a full release between each.
   -> o_value = 32'h23456789, o_digit_count = 8.
4. Key 'D' (row3, col3) low for 2 samples, then high.
   -> No strobe; o_value is unchanged; FSM returns to SCAN at column 0.
5. Rows 0 and 2 both low on col0.
   -> No strobe; column keeps advancing. Then single key 'A' -> o_key = A.
6. With o_value = 32'h12, pulse i_clear on the accept cycle of key '7'.
   -> o_key_valid = 1, o_key = 7, o_value = 0, count = 0. Then assert i_rst mid-DEBOUNCE -> all reset values, and no strobe after release.
